// File: rtl/gemm_cmd_sequencer.sv
// gemm_fifo: circular command buffer with a separate occupancy register.
// Latency: a push is visible at the head on the cycle after the write edge; there is no bypass path.
// Backpressure: pushes are dropped while full unless a pop happens in the same cycle.
//   Ports: push_vld/push_dat write the tail; pop_vld advances the head;
//   head_dat is the head entry, or 0 while empty; empty/full/count report occupancy.
module gemm_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop_ok   = pop_vld && !empty;
    // A pop in the same cycle frees the slot this push lands in.
    assign push_ok  = push_vld && (!full || pop_ok);
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// gemm_cmd_sequencer: queues GEMM custom instructions from the core and issues them to the engine.
// Latency: request-to-gemm_done 1 cycle when space exists; a queued entry reaches cmd_valid the cycle after its write.
// Backpressure: core stalls (no gemm_done) while the FIFO is full or a SYNC waits for drain; issue capped at MAX_INFLIGHT.
//   Ports: gemm_valid/gemm_instruction/gemm_rdata1/gemm_rdata2 in, gemm_done out (core side);
//   cmd_valid/cmd_ready/cmd_instr/cmd_op1/cmd_op2 and eng_done (engine side);
//   busy and fifo_count report status. rst is asynchronous, active-low.
module gemm_cmd_sequencer #(
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       gemm_valid,
    input  logic [31:0]                gemm_instruction,
    input  logic [31:0]                gemm_rdata1,
    input  logic [31:0]                gemm_rdata2,
    output logic                       gemm_done,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [31:0]                cmd_instr,
    output logic [31:0]                cmd_op1,
    output logic [31:0]                cmd_op2,
    input  logic                       eng_done,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] op1;
        logic [31:0] op2;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, WAIT_SPACE, WAIT_DRAIN, ACK} state_t;

    localparam logic [3:0] MAX_IF = 4'(MAX_INFLIGHT);
    localparam logic [3:0] IF_ONE = 4'd1;

    state_t     state;
    state_t     state_nxt;
    cmd_t       push_dat;
    cmd_t       head_dat;
    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic       fifo_full;
    logic       is_sync;
    logic [3:0] inflight;
    logic       sticky_err;
    logic       spurious_done;

    assign is_sync  = (gemm_instruction[14:12] == 3'b111);
    assign push_dat = '{instr: gemm_instruction, op1: gemm_rdata1, op2: gemm_rdata2};

    gemm_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push),
        .push_dat (push_dat),
        .pop_vld  (pop),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    assign cmd_valid = !fifo_empty && (inflight < MAX_IF);
    assign pop       = cmd_valid && cmd_ready;
    assign cmd_instr = head_dat.instr;
    assign cmd_op1   = head_dat.op1;
    assign cmd_op2   = head_dat.op2;
    assign busy      = !fifo_empty || (inflight != '0) || (state != IDLE);

    // A completion with nothing outstanding is a protocol error from the engine.
    assign spurious_done = eng_done && (inflight == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            inflight   <= '0;
            sticky_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            sticky_err <= sticky_err | spurious_done;
            // A spurious done is dropped, so only the pop counts in that case.
            if (pop && (!eng_done || spurious_done)) begin
                inflight <= inflight + IF_ONE;
            end else if (!pop && eng_done && !spurious_done) begin
                inflight <= inflight - IF_ONE;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        gemm_done = 1'b0;
        case (state)
            IDLE: begin
                if (gemm_valid) begin
                    if (is_sync) begin
                        state_nxt = WAIT_DRAIN;
                    end else if (!fifo_full) begin
                        push      = 1'b1;
                        state_nxt = ACK;
                    end else begin
                        state_nxt = WAIT_SPACE;
                    end
                end
            end
            WAIT_SPACE: begin
                // The slot freed by a same-cycle pop is usable immediately.
                if (!fifo_full || pop) begin
                    push      = 1'b1;
                    state_nxt = ACK;
                end
            end
            WAIT_DRAIN: begin
                if (fifo_empty && (inflight == '0) && !eng_done) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                gemm_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_gemm_cmd_sequencer.sv
module tb_gemm_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gemm_valid = 1'b0;
    logic [31:0] gemm_instruction = '0;
    logic [31:0] gemm_rdata1 = '0;
    logic [31:0] gemm_rdata2 = '0;
    logic        gemm_done;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [31:0] cmd_instr;
    logic [31:0] cmd_op1;
    logic [31:0] cmd_op2;
    logic        eng_done = 1'b0;
    logic        busy;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gemm_cmd_sequencer #(.DEPTH(4), .MAX_INFLIGHT(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .gemm_valid       (gemm_valid),
        .gemm_instruction (gemm_instruction),
        .gemm_rdata1      (gemm_rdata1),
        .gemm_rdata2      (gemm_rdata2),
        .gemm_done        (gemm_done),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_instr        (cmd_instr),
        .cmd_op1          (cmd_op1),
        .cmd_op2          (cmd_op2),
        .eng_done         (eng_done),
        .busy             (busy),
        .fifo_count       (fifo_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        gemm_valid = 1'b0; cmd_ready = 1'b0; eng_done = 1'b0;
        gemm_instruction = '0; gemm_rdata1 = '0; gemm_rdata2 = '0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Holds a request until gemm_done (bounded), then lets the FSM return to IDLE.
    task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2, output int lat);
        gemm_valid = 1'b1; gemm_instruction = ins; gemm_rdata1 = r1; gemm_rdata2 = r2;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!gemm_done && lat < 20);
        if (!gemm_done) lat = -1;
        gemm_valid = 1'b0; gemm_instruction = '0; gemm_rdata1 = '0; gemm_rdata2 = '0;
        tick();
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({gemm_done, cmd_valid, busy, fifo_count} !== 6'd0) begin n_err++; $display("FAIL reset_async: got %b want 0", {gemm_done, cmd_valid, busy, fifo_count}); end
        tick();
        n_cmp++; if ({cmd_instr, cmd_op1, cmd_op2} !== 96'd0) begin n_err++; $display("FAIL reset_cmd_data: got %h want 0", {cmd_instr, cmd_op1, cmd_op2}); end
        n_cmp++; if (dut.inflight !== 4'd0) begin n_err++; $display("FAIL reset_inflight: got %0d want 0", dut.inflight); end
        rst = 1'b1;
        tick();
        n_cmp++; if ({gemm_done, cmd_valid, busy, fifo_count} !== 6'd0) begin n_err++; $display("FAIL reset_release: got %b want 0", {gemm_done, cmd_valid, busy, fifo_count}); end
    endtask

    task automatic test_single();
        cmd_ready = 1'b1;
        gemm_valid = 1'b1; gemm_instruction = 32'h0000_000B; gemm_rdata1 = 32'd5; gemm_rdata2 = 32'd7;
        tick();
        n_cmp++; if (gemm_done !== 1'b1) begin n_err++; $display("FAIL single_done: got %b want 1", gemm_done); end
        n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL single_cmd_valid: got %b want 1", cmd_valid); end
        n_cmp++; if ({cmd_instr, cmd_op1, cmd_op2} !== {32'h0000_000B, 32'd5, 32'd7}) begin n_err++; $display("FAIL single_cmd_data: got %h want %h", {cmd_instr, cmd_op1, cmd_op2}, {32'h0000_000B, 32'd5, 32'd7}); end
        // Operands changed after the write must not reach the queued entry.
        gemm_valid = 1'b0; gemm_rdata1 = 32'hDEAD; gemm_rdata2 = 32'hBEEF;
        tick();
        n_cmp++; if ({gemm_done, cmd_valid, fifo_count} !== 5'b0_0_000) begin n_err++; $display("FAIL single_after_pop: got %b want 00000", {gemm_done, cmd_valid, fifo_count}); end
        n_cmp++; if (dut.inflight !== 4'd1) begin n_err++; $display("FAIL single_inflight: got %0d want 1", dut.inflight); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    endtask

    task automatic test_full();
        int lat;
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(32'h0000_0100 + i, 32'h10 + i, 32'h20 + i, lat);
            n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL full_ack_lat%0d: got %0d want 1", i, lat); end
        end
        n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        gemm_valid = 1'b1; gemm_instruction = 32'h0000_0104; gemm_rdata1 = 32'h14; gemm_rdata2 = 32'h24;
        tick();
        tick();
        n_cmp++; if ({gemm_done, fifo_count} !== 4'b0_100) begin n_err++; $display("FAIL full_wait_space: got %b want 0100", {gemm_done, fifo_count}); end
        n_cmp++; if ({cmd_valid, cmd_op1} !== {1'b1, 32'h10}) begin n_err++; $display("FAIL full_head_stable: got %h want %h", {cmd_valid, cmd_op1}, {1'b1, 32'h10}); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        n_cmp++; if ({gemm_done, fifo_count} !== 4'b1_100) begin n_err++; $display("FAIL full_pop_push: got %b want 1100", {gemm_done, fifo_count}); end
        n_cmp++; if (cmd_op1 !== 32'h11) begin n_err++; $display("FAIL full_head_next: got %h want 11", cmd_op1); end
        gemm_valid = 1'b0;
        tick();
        n_cmp++; if (gemm_done !== 1'b0) begin n_err++; $display("FAIL full_done_pulse: got %b want 0", gemm_done); end
    endtask

    task automatic test_inflight_cap();
        int lat;
        int pops;
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(32'h0000_0200 + i, 32'h30 + i, 32'h40 + i, lat);
        n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL cap_count: got %0d want 3", fifo_count); end
        cmd_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            if (cmd_valid && cmd_ready) pops++;
            tick();
        end
        n_cmp++; if (pops !== 2) begin n_err++; $display("FAIL cap_pops: got %0d want 2", pops); end
        n_cmp++; if ({cmd_valid, fifo_count} !== 4'b0_001) begin n_err++; $display("FAIL cap_blocked: got %b want 0001", {cmd_valid, fifo_count}); end
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        n_cmp++; if ({cmd_valid, cmd_op1} !== {1'b1, 32'h32}) begin n_err++; $display("FAIL cap_third_valid: got %h want %h", {cmd_valid, cmd_op1}, {1'b1, 32'h32}); end
        tick();
        n_cmp++; if ({cmd_valid, fifo_count, dut.inflight} !== {1'b0, 3'd0, 4'd2}) begin n_err++; $display("FAIL cap_third_pop: got %b want 00000010", {cmd_valid, fifo_count, dut.inflight}); end
    endtask

    task automatic test_sync();
        int lat;
        int early;
        cmd_ready = 1'b0;
        issue(32'h0000_0300, 32'h50, 32'h60, lat);
        issue(32'h0000_0301, 32'h51, 32'h61, lat);
        gemm_valid = 1'b1; gemm_instruction = 32'h0000_700B;
        tick();
        n_cmp++; if ({gemm_done, fifo_count} !== 4'b0_010) begin n_err++; $display("FAIL sync_no_enqueue: got %b want 0010", {gemm_done, fifo_count}); end
        cmd_ready = 1'b1;
        early = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (gemm_done) early++;
        end
        n_cmp++; if (dut.inflight !== 4'd2) begin n_err++; $display("FAIL sync_inflight: got %0d want 2", dut.inflight); end
        eng_done = 1'b1;
        tick();
        if (gemm_done) early++;
        eng_done = 1'b0;
        tick();
        if (gemm_done) early++;
        tick();
        if (gemm_done) early++;
        n_cmp++; if (early !== 0) begin n_err++; $display("FAIL sync_early_done: got %0d acks want 0", early); end
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        n_cmp++; if (gemm_done !== 1'b0) begin n_err++; $display("FAIL sync_last_edge: got %b want 0", gemm_done); end
        tick();
        n_cmp++; if (gemm_done !== 1'b1) begin n_err++; $display("FAIL sync_ack: got %b want 1", gemm_done); end
        gemm_valid = 1'b0; gemm_instruction = '0;
        tick();
        n_cmp++; if ({gemm_done, busy} !== 2'b00) begin n_err++; $display("FAIL sync_idle: got %b want 00", {gemm_done, busy}); end
    endtask

    task automatic test_done_corner();
        int lat;
        cmd_ready = 1'b0;
        issue(32'h0000_0400, 32'h70, 32'h80, lat);
        issue(32'h0000_0401, 32'h71, 32'h81, lat);
        cmd_ready = 1'b1;
        tick();
        n_cmp++; if (dut.inflight !== 4'd1) begin n_err++; $display("FAIL corner_first_pop: got %0d want 1", dut.inflight); end
        eng_done = 1'b1;
        tick();
        cmd_ready = 1'b0;
        n_cmp++; if ({dut.inflight, fifo_count} !== {4'd1, 3'd0}) begin n_err++; $display("FAIL corner_pop_and_done: got %b want 0001000", {dut.inflight, fifo_count}); end
        tick();
        n_cmp++; if ({dut.inflight, dut.sticky_err} !== {4'd0, 1'b0}) begin n_err++; $display("FAIL corner_drain: got %b want 00000", {dut.inflight, dut.sticky_err}); end
        tick();
        eng_done = 1'b0;
        n_cmp++; if ({dut.inflight, dut.sticky_err} !== {4'd0, 1'b1}) begin n_err++; $display("FAIL corner_spurious: got %b want 00001", {dut.inflight, dut.sticky_err}); end
    endtask

    task automatic test_reset_midrun();
        int lat;
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(32'h0000_0500 + i, 32'h90 + i, 32'hA0 + i, lat);
        n_cmp++; if ({fifo_count, busy, cmd_valid} !== {3'd3, 1'b1, 1'b1}) begin n_err++; $display("FAIL midrun_loaded: got %b want 01111", {fifo_count, busy, cmd_valid}); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({gemm_done, cmd_valid, busy, fifo_count} !== 6'd0) begin n_err++; $display("FAIL midrun_async: got %b want 0", {gemm_done, cmd_valid, busy, fifo_count}); end
        tick();
        n_cmp++; if ({gemm_done, cmd_valid, busy, fifo_count, cmd_instr, cmd_op1, cmd_op2} !== 102'd0) begin n_err++; $display("FAIL midrun_edge: outputs %h want 0", {gemm_done, cmd_valid, busy, fifo_count, cmd_instr, cmd_op1, cmd_op2}); end
        rst = 1'b1;
        tick();
        n_cmp++; if ({cmd_valid, fifo_count, dut.inflight} !== 8'd0) begin n_err++; $display("FAIL midrun_release: got %b want 0", {cmd_valid, fifo_count, dut.inflight}); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        do_reset();
        test_full();
        do_reset();
        test_inflight_cap();
        do_reset();
        test_sync();
        do_reset();
        test_done_corner();
        do_reset();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
